// File: rtl/mcu_pkg.sv
// rtl/mcu_pkg.sv - shared constants and FSM state type for the mcu sequencer
package mcu_pkg;

    localparam int DATA_W = 4;

    localparam logic [1:0] CLS_ALU   = 2'b00;
    localparam logic [1:0] CLS_LOAD  = 2'b01;
    localparam logic [1:0] CLS_STORE = 2'b10;
    localparam logic [1:0] CLS_LDI   = 2'b11;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_EXEC      = 2'd1,
        ST_LOAD_WAIT = 2'd2
    } state_t;

endpackage

// File: rtl/mcu_regfile.sv
// rtl/mcu_regfile.sv - 4x4 register file, two async read ports, one sync write port
module mcu_regfile
    import mcu_pkg::*;
#(
    parameter logic [DATA_W-1:0] REG_INIT = 4'h0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        ra_addr,
    output logic [DATA_W-1:0] ra_data,
    input  logic [1:0]        rb_addr,
    output logic [DATA_W-1:0] rb_data,
    input  logic              we,
    input  logic [1:0]        waddr,
    input  logic [DATA_W-1:0] wdata
);

    logic [DATA_W-1:0] regs [4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                regs[i] <= REG_INIT;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign ra_data = regs[ra_addr];
    assign rb_data = regs[rb_addr];

endmodule

// File: rtl/mcu_sequencer.sv
// rtl/mcu_sequencer.sv - 8-bit instruction sequencer driving an external ALU and RAM
// Optional zero flag output enabled by MCU_SEQ_ZERO_FLAG_EN.
module mcu_sequencer
    import mcu_pkg::*;
#(
    parameter logic [DATA_W-1:0] REG_INIT = 4'h0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [1:0]        alu_opcode,
    input  logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              busy,
    output logic              retire
`ifdef MCU_SEQ_ZERO_FLAG_EN
    ,
    output logic              zero
`endif
);

    state_t            state_q, state_d;
    logic [7:0]        ir_q;
    logic [1:0]        cls;
    logic [1:0]        ra_addr;
    logic [DATA_W-1:0] ra_data, rb_data;
    logic              wr_en;
    logic [1:0]        wr_addr;
    logic [DATA_W-1:0] wr_data;

    assign cls = ir_q[7:6];
    // Port A serves the ALU destination operand or the STORE source register.
    assign ra_addr = (cls == CLS_ALU) ? ir_q[3:2] : ir_q[5:4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ir_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && instr_valid) begin
                ir_q <= instr;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        instr_ready = 1'b0;
        busy        = 1'b1;
        retire      = 1'b0;
        alu_a       = '0;
        alu_b       = '0;
        alu_opcode  = OP_ADD;
        ram_addr    = '0;
        ram_din     = '0;
        ram_we      = 1'b0;
        wr_en       = 1'b0;
        wr_addr     = ir_q[5:4];
        wr_data     = ir_q[3:0];
        case (state_q)
            ST_IDLE: begin
                busy        = 1'b0;
                instr_ready = 1'b1;
                if (instr_valid) begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (cls)
                    CLS_ALU: begin
                        alu_a      = ra_data;
                        alu_b      = rb_data;
                        alu_opcode = ir_q[5:4];
                        wr_en      = 1'b1;
                        wr_addr    = ir_q[3:2];
                        wr_data    = alu_result;
                        retire     = 1'b1;
                        state_d    = ST_IDLE;
                    end
                    CLS_LOAD: begin
                        ram_addr = ir_q[3:0];
                        state_d  = ST_LOAD_WAIT;
                    end
                    CLS_STORE: begin
                        ram_addr = ir_q[3:0];
                        ram_din  = ra_data;
                        ram_we   = 1'b1;
                        retire   = 1'b1;
                        state_d  = ST_IDLE;
                    end
                    default: begin
                        wr_en   = 1'b1;
                        retire  = 1'b1;
                        state_d = ST_IDLE;
                    end
                endcase
            end
            ST_LOAD_WAIT: begin
                ram_addr = ir_q[3:0];
                wr_en    = 1'b1;
                wr_data  = ram_dout;
                retire   = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    mcu_regfile #(
        .REG_INIT (REG_INIT)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .ra_addr (ra_addr),
        .ra_data (ra_data),
        .rb_addr (ir_q[1:0]),
        .rb_data (rb_data),
        .we      (wr_en),
        .waddr   (wr_addr),
        .wdata   (wr_data)
    );

`ifdef MCU_SEQ_ZERO_FLAG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero <= 1'b0;
        end else if (wr_en) begin
            zero <= (wr_data == '0);
        end
    end
`endif

endmodule

// File: tb/tb_mcu_sequencer.sv
// tb/tb_mcu_sequencer.sv - self-checking bench: per-instruction cycle model plus directed pins
module tb_mcu_sequencer;

    localparam logic [3:0] INIT = 4'h0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] instr = 8'h00;
    logic       instr_valid = 1'b0;
    logic       instr_ready, ram_we, busy, retire;
    logic [3:0] alu_a, alu_b, alu_result, ram_addr, ram_din;
    logic [3:0] ram_dout = 4'h0;
    logic [1:0] alu_opcode;
`ifdef MCU_SEQ_ZERO_FLAG_EN
    logic       zero;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mcu_sequencer #(.REG_INIT(INIT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_opcode  (alu_opcode),
        .alu_result  (alu_result),
        .ram_addr    (ram_addr),
        .ram_din     (ram_din),
        .ram_we      (ram_we),
        .ram_dout    (ram_dout),
        .busy        (busy),
        .retire      (retire)
`ifdef MCU_SEQ_ZERO_FLAG_EN
        ,
        .zero        (zero)
`endif
    );

    function automatic logic [3:0] alu_f(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a & b;
            default: return a | b;
        endcase
    endfunction

    // Environment: combinational ALU and a RAM with one cycle of read latency.
    logic [3:0] ram [16];
    assign alu_result = alu_f(alu_opcode, alu_a, alu_b);
    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_din;
        ram_dout <= ram[ram_addr];
    end

    // Model: each accepted instruction expands into the list of cycles it must produce.
    typedef struct {
        bit busy, ready, retire, we, wr;
        bit [3:0] a, b, addr, din, wd;
        bit [1:0] op, wa;
    } cyc_t;

    cyc_t       q[$];
    logic [3:0] mreg [4];
    logic [3:0] mmem [16];
    logic       mzero;
    int         acc_cnt = 0;

    function automatic cyc_t idle_c();
        cyc_t c;
        c = '{default: 0};
        c.ready = 1'b1;
        return c;
    endfunction

    function automatic void accept(input logic [7:0] w);
        cyc_t c;
        c = '{default: 0};
        c.busy = 1'b1;
        case (w[7:6])
            2'd0: begin
                c.a = mreg[w[3:2]]; c.b = mreg[w[1:0]]; c.op = w[5:4];
                c.retire = 1; c.wr = 1; c.wa = w[3:2]; c.wd = alu_f(w[5:4], c.a, c.b);
                q.push_back(c);
            end
            2'd1: begin
                c.addr = w[3:0];
                q.push_back(c);
                c.retire = 1; c.wr = 1; c.wa = w[5:4]; c.wd = mmem[w[3:0]];
                q.push_back(c);
            end
            2'd2: begin
                c.addr = w[3:0]; c.din = mreg[w[5:4]]; c.we = 1; c.retire = 1;
                q.push_back(c);
            end
            default: begin
                c.retire = 1; c.wr = 1; c.wa = w[5:4]; c.wd = w[3:0];
                q.push_back(c);
            end
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        cyc_t c;
        if (!rst_n) begin
            q.delete();
            for (int i = 0; i < 4; i++) mreg[i] = INIT;
            mzero = 1'b0;
        end else if (q.size() > 0) begin
            c = q.pop_front();
            if (c.wr) begin
                mreg[c.wa] = c.wd;
                mzero = (c.wd == 4'h0);
            end
            if (c.we) mmem[c.addr] = c.din;
        end else if (instr_valid) begin
            accept(instr);
            acc_cnt++;
        end
    end

    task automatic chk(input string n, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        cyc_t e;
        if (rst_n) begin
            e = (q.size() > 0) ? q[0] : idle_c();
            chk("busy", busy, e.busy);
            chk("instr_ready", instr_ready, e.ready);
            chk("retire", retire, e.retire);
            chk("ram_we", ram_we, e.we);
            chk("ram_addr", ram_addr, e.addr);
            chk("ram_din", ram_din, e.din);
            chk("alu_a", alu_a, e.a);
            chk("alu_b", alu_b, e.b);
            chk("alu_opcode", alu_opcode, e.op);
`ifdef MCU_SEQ_ZERO_FLAG_EN
            chk("zero", zero, mzero);
`endif
        end
    end

    task automatic send(input logic [7:0] w, input bit keep, output int lat);
        int start;
        start = acc_cnt;
        lat = 0;
        instr = w;
        instr_valid = 1'b1;
        while (acc_cnt == start && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (acc_cnt == start) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: word %0h not accepted within %0d cycles", w, lat);
        end
        if (!keep) instr_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: %0d cycles still pending", q.size());
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [3:0] v;
        for (int i = 0; i < 16; i++) begin
            v = 4'($urandom);
            ram[i] = v;
            mmem[i] = v;
        end
        instr = 8'hD5;
        instr_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_retire", retire, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_ram_addr", ram_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // LDI R1,#5 accepted on the first edge after reset release
        send(8'hD5, 0, lat);
        chk("first_accept_lat", 8'(lat), 1);
        drain();
        send(8'hE3, 0, lat);
        drain();
        send(8'h06, 0, lat);
        @(negedge clk);
        chk("add_alu_a", alu_a, 5);
        chk("add_alu_b", alu_b, 3);
        chk("add_opcode", alu_opcode, 0);
        chk("add_retire", retire, 1);
        drain();

        send(8'h94, 0, lat);
        @(negedge clk);
        chk("store_we", ram_we, 1);
        chk("store_addr", ram_addr, 4);
        chk("store_din", ram_din, 8);
        @(negedge clk);
        chk("store_we_after", ram_we, 0);

        send(8'h74, 0, lat);
        @(negedge clk);
        chk("load_busy1", busy, 1);
        chk("load_retire1", retire, 0);
        @(negedge clk);
        chk("load_busy2", busy, 1);
        chk("load_retire2", retire, 1);
        @(negedge clk);
        chk("load_busy3", busy, 0);
        send(8'hB0, 0, lat);
        @(negedge clk);
        chk("r3_after_load", ram_din, 8);
        drain();

        send(8'hCF, 0, lat);
        drain();
        send(8'h10, 0, lat);
        @(negedge clk);
        chk("sub_alu_a", alu_a, 4'hF);
        chk("sub_alu_b", alu_b, 4'hF);
        chk("sub_opcode", alu_opcode, 1);
        drain();
        send(8'h80, 0, lat);
        @(negedge clk);
        chk("sub_result", ram_din, 0);
        drain();
        send(8'hCF, 0, lat);
        drain();
        send(8'hD1, 0, lat);
        drain();
        send(8'h01, 0, lat);
        @(negedge clk);
        chk("wrap_alu_a", alu_a, 4'hF);
        chk("wrap_alu_b", alu_b, 1);
        drain();
`ifdef MCU_SEQ_ZERO_FLAG_EN
        chk("wrap_zero", zero, 1);
`endif
        send(8'h85, 0, lat);
        @(negedge clk);
        chk("wrap_result", ram_din, 0);
        drain();

        // Reset while waiting on LOAD data must abort the write.
        send(8'h74, 0, lat);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_retire", retire, 0);
        chk("abort_ram_we", ram_we, 0);
        chk("abort_ram_addr", ram_addr, 0);
        #1;
        rst_n = 1'b1;
        send(8'hB6, 0, lat);
        @(negedge clk);
        chk("abort_r3_init", ram_din, INIT);
        drain();

        // Random stream; keep=1 leaves instr_valid high straight into the next word.
        for (int i = 0; i < 400; i++) begin
            send(8'($urandom), bit'($urandom_range(0, 1)), lat);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            if ($urandom_range(0, 59) == 0) begin
                #($urandom_range(1, 2));
                rst_n = 1'b0;
                #1;
                chk("rand_rst_busy", busy, 0);
                rst_n = 1'b1;
            end
        end
        instr_valid = 1'b0;
        drain();
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
